// File: rtl/io881_task_scheduler.sv
// io881_task_scheduler: round-robin (channel, thread) task scheduler.
// Keeps a runnable bitmap, offers the next task to the fetch unit on the
// next_task_* handshake and tracks the running task through suspend/yield.
module io881_task_scheduler #(
  parameter int CH_BITS = 3,
  parameter int TH_BITS = 2,
  localparam int IDX_BITS = CH_BITS + TH_BITS,
  localparam int SLOTS = 2 ** IDX_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SLOTS-1:0]   wake,
  input  logic               suspend,
  input  logic               yield,
  output logic [CH_BITS-1:0] next_task_channel,
  output logic [TH_BITS-1:0] next_task_thread,
  output logic               next_task_ready,
  input  logic               next_task_ack,
  output logic [CH_BITS-1:0] cur_channel,
  output logic [TH_BITS-1:0] cur_thread,
  output logic               running,
  output logic               idle
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [SLOTS-1:0]    runnable_reg, runnable_next;
  logic [IDX_BITS-1:0] last_grant_reg;
  logic [IDX_BITS-1:0] offer_idx_reg;
  logic [IDX_BITS-1:0] cur_idx_reg;

  logic [SLOTS-1:0]    clr_mask, set_mask;
  logic [IDX_BITS-1:0] start_idx;
  logic [IDX_BITS-1:0] cand_idx [SLOTS];
  logic [SLOTS-1:0]    rot_bits;
  logic [IDX_BITS-1:0] pick_idx;
  logic                accept, stop_task;

  assign accept    = (state_reg == OFFER) && next_task_ack;
  // Suspend and yield both end the running task; suspend only differs in
  // not re-marking the slot runnable.
  assign stop_task = (state_reg == RUN) && (suspend || yield);

  // Bitmap update: dispatch clears the offered slot, a yield re-marks the
  // running slot, and wakes are ORed last so a same-edge wake always sticks.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (accept) begin
      clr_mask[offer_idx_reg] = 1'b1;
    end
    if ((state_reg == RUN) && yield && !suspend) begin
      set_mask[cur_idx_reg] = 1'b1;
    end
    runnable_next = (runnable_reg & ~clr_mask) | set_mask | wake;
  end

  // Candidate order: slot last_grant+1 first, wrapping, so the last grant is
  // considered last. Index arithmetic wraps naturally at SLOTS.
  assign start_idx = last_grant_reg + IDX_BITS'(1);

  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_cand
      assign cand_idx[gi] = start_idx + IDX_BITS'(gi);
      assign rot_bits[gi] = runnable_next[cand_idx[gi]];
    end
  endgenerate

  // First set bit in scan order; the search sees same-edge wakes and the
  // yield re-mark so a task switch can re-offer in one edge.
  always_comb begin
    pick_idx = start_idx;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (rot_bits[i]) begin
        pick_idx = cand_idx[i];
      end
    end
  end

  // State register and scheduler bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      runnable_reg   <= SLOTS'(1);
      last_grant_reg <= '1;
      offer_idx_reg  <= '0;
      cur_idx_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      runnable_reg <= runnable_next;
      if ((state_next == OFFER) && (state_reg != OFFER)) begin
        offer_idx_reg <= pick_idx;
      end
      if (accept) begin
        last_grant_reg <= offer_idx_reg;
        cur_idx_reg    <= offer_idx_reg;
      end
    end
  end

  // Next-state logic; an offer is never retargeted while it is pending.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (runnable_reg != '0) state_next = OFFER;
      OFFER:   if (next_task_ack) state_next = RUN;
      RUN:     if (stop_task) state_next = (runnable_next != '0) ? OFFER : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state and index registers.
  always_comb begin
    next_task_ready   = (state_reg == OFFER);
    running           = (state_reg == RUN);
    idle              = (state_reg == IDLE) && (runnable_reg == '0);
    next_task_channel = offer_idx_reg[IDX_BITS-1:TH_BITS];
    next_task_thread  = offer_idx_reg[TH_BITS-1:0];
    cur_channel       = cur_idx_reg[IDX_BITS-1:TH_BITS];
    cur_thread        = cur_idx_reg[TH_BITS-1:0];
  end

endmodule

// File: doc/io881_task_scheduler.md
Name: io881_task_scheduler

Overview:
- Round-robin scheduler that selects the next (channel, thread) task for the instruction fetch unit and offers it on the next_task_* handshake.
- Holds a runnable bitmap over all channel/thread slots. Slots are set by wake pulses from channel hardware and cleared when a task is dispatched.
- Tracks the currently running task and handles suspend and yield requests from the decode/fetch pipeline.
- Sits between the channel wake logic and the instruction fetch unit, whose memory address is {channel, 12-bit pc}.

Parameters:
- CH_BITS, 3, channel index width; channel count = 2**CH_BITS.
- TH_BITS, 2, thread index width; threads per channel = 2**TH_BITS.
- SLOTS, 2**(CH_BITS+TH_BITS), derived; total task slots (default 32).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset.
- wake  input  SLOTS  one pulse per slot; bit index = channel*2**TH_BITS + thread.
- suspend  input  1  1-cycle pulse: the running task stops and is not runnable until woken.
- yield  input  1  1-cycle pulse: the running task stops and stays runnable.
- next_task_channel  output  CH_BITS  channel of the offered task.
- next_task_thread  output  TH_BITS  thread of the offered task.
- next_task_ready  output  1  an offer is valid.
- next_task_ack  input  1  fetch unit accepts the offer.
- cur_channel  output  CH_BITS  channel of the running task.
- cur_thread  output  TH_BITS  thread of the running task.
- running  output  1  a task is currently dispatched.
- idle  output  1  no task is running or offered, and the runnable bitmap is zero.

Behaviour:
- Reset (reset=0, async):
  - runnable = SLOTS'b1 (only slot 0, i.e. channel 0 thread 0, is the boot task).
  - last_grant = SLOTS-1, so the first search starts at slot 0.
  - state = IDLE.
  - All outputs = 0, except idle, which is combinational and reads 0 because slot 0 is runnable.
- States:
  - IDLE: no task running or offered.
  - OFFER: next_task_ready=1.
  - RUN: running=1.
- Search (combinational):
  - Finds the first set bit of runnable, scanning from (last_grant+1) mod SLOTS upward and wrapping.
  - channel = index >> TH_BITS; thread = index & (2**TH_BITS-1).
- IDLE -> OFFER:
  - Transition happens on the first posedge at which runnable != 0.
  - The search result is registered into next_task_channel/thread.
  - next_task_ready rises that edge.
- OFFER:
  - channel, thread and ready stay stable until ack; the offer is never retargeted, even if a lower-index slot wakes.
  - On the posedge with next_task_ack=1:
    - clear the offered runnable bit;
    - last_grant = offered index;
    - cur_* = offered;
    - ready = 0, running = 1, state = RUN.
  - A wake for the offered slot during OFFER, including on the ack edge, leaves that bit set after dispatch. The task will run again.
- RUN:
  - suspend: running=0; the slot stays clear unless a wake for it arrives on the same edge.
  - yield: running=0; set the running slot's runnable bit.
  - If suspend and yield are asserted together, suspend wins.
  - Next state after suspend or yield: OFFER on the same edge if the post-update runnable is nonzero, else IDLE. This gives one-edge task-switch latency, and the new offer appears the cycle after the pulse.
  - With yield and no other runnable slot, the same task is re-offered.
  - ack, suspend or yield in states where they do not apply are ignored.
- Wake handling:
  - wake bits OR into runnable every cycle in every state.
  - A wake for the running task sets its bit, so the task is re-offered after it stops.
  - A wake of an already-set bit has no effect; there is no counting.
- Fairness: after a grant of slot k, slot k is the last candidate considered, so no slot waits more than SLOTS-1 grants.
- Mid-operation reset: reset asserted in OFFER or RUN drops ready/running asynchronously and restores the reset bitmap; in-flight acks are lost.
- cur_* hold their last value when running=0.

Test Plan:
1. Release reset, no stimulus -> next cycle next_task_ready=1, channel=0, thread=0. Ack -> running=1, cur=0/0, idle=0, next_task_ready=0.
2. Running 0/0. wake bits 13 (ch3 th1) and 4 (ch1 th0) pulse together, then suspend -> offer ch1 th0. Ack, suspend -> offer ch3 th1. Ack, suspend -> idle=1, ready=0.
3. Wrap-around:
   - Setup: wake bit 31 (ch7 th3); ack; suspend, with no other bit set.
   - Then wake bits 31 and 2 together -> offer ch0 th2 (scan wraps past 31 and slot 31 is considered last), then ch7 th3.
4. Offer ch2 th0 held with ack=0 for 5 cycles while bit 0 wakes -> channel/thread stay 2/0 throughout. Ack -> runs 2/0. Suspend -> offer 0/0.
5. Running ch5 th1. Suspend and wake bit 21 on the same edge -> next cycle ready=1 with 5/1. Yield alone with an empty bitmap -> the same task is re-offered next cycle.
6. Assert reset low during RUN of ch4 th2 -> running, ready and cur drop to 0 immediately. After release, the boot offer is 0/0.
